// File: rtl/ram_rd_stream_pkg.sv
// rtl/ram_rd_stream_pkg.sv - shared types and helpers for the RAM read stream controller
package ram_rd_stream_pkg;

   typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

   localparam int C_MIN_TAG_W = 1;

   function automatic int clog2(input int value);
      int r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // One tag bit per RAM output pipeline stage.
   function automatic int tag_width(input int latency);
      return (latency < C_MIN_TAG_W) ? C_MIN_TAG_W : latency;
   endfunction

endpackage

// File: rtl/rd_stream_skid_fifo.sv
// rtl/rd_stream_skid_fifo.sv - first-word-fall-through skid FIFO for the read stream
module rd_stream_skid_fifo
   import ram_rd_stream_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int PW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
   localparam int CW = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && full));
   end

endmodule

// File: rtl/ram_rd_stream_ctrl.sv
// rtl/ram_rd_stream_ctrl.sv - burst read sequencer turning RAM reads into a valid/ready stream
module ram_rd_stream_ctrl
   import ram_rd_stream_pkg::*;
#(
   parameter int C_RAM_RD_WIDTH = 32,
   parameter int C_RAM_RD_DEPTH = 1024,
   parameter int C_RD_LATENCY   = 3,
   parameter int C_SKID_DEPTH   = 4,
   localparam int AW = clog2(C_RAM_RD_DEPTH),
   localparam int NW = AW + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [AW-1:0]             base_addr,
   input  logic [NW-1:0]             num_words,
   output logic                      busy,
   output logic                      done,
   output logic [AW-1:0]             rdAddr,
   output logic                      rden,
   input  logic [C_RAM_RD_WIDTH-1:0] ram_dout,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [C_RAM_RD_WIDTH-1:0] m_data,
   output logic                      m_last
);

   localparam int TW  = tag_width(C_RD_LATENCY);
   localparam int FCW = clog2(C_SKID_DEPTH) + 1;
   localparam int SW  = clog2(C_SKID_DEPTH + C_RD_LATENCY + 2) + 1;
   localparam int LW  = clog2(C_RD_LATENCY) + 1;

   state_t                    state, state_nx;
   logic [AW-1:0]             addr_q;
   logic [NW-1:0]             issue_left, out_left;
   logic [LW-1:0]             flush_left;
   logic [TW-1:0]             tag, tag_nx;
   logic                      push_pending, issue_real, credit_ok, pop, last_accept;
   logic [SW-1:0]             inflight_real, credit_need;
   logic [FCW-1:0]            fifo_count;
   logic                      fifo_empty, fifo_full;
   logic [C_RAM_RD_WIDTH-1:0] fifo_data;

   // Top tag bit marks a real word now on ram_dout; it is pushed on the next edge.
   assign push_pending = tag[TW-1];
   assign issue_real   = (state == RUN);
   assign rdAddr       = addr_q;
   assign m_valid      = !fifo_empty;
   assign m_data       = m_valid ? fifo_data : '0;
   assign m_last       = m_valid && (out_left == NW'(1));
   assign pop          = m_valid && m_ready;
   assign last_accept  = pop && (out_left == NW'(1));

   always_comb begin
      inflight_real = '0;
      for (int i = 0; i < TW - 1; i++) inflight_real = inflight_real + SW'(tag[i]);
      credit_need = SW'(fifo_count) + SW'(push_pending) + inflight_real + SW'(issue_real);
      credit_ok   = !fifo_full && (credit_need <= SW'(C_SKID_DEPTH));
   end

   always_comb begin
      tag_nx       = tag;
      tag_nx[TW-1] = 1'b0;
      if (rden) begin
         for (int i = TW - 1; i > 0; i--) tag_nx[i] = tag[i-1];
         tag_nx[0] = issue_real;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      rden     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = (num_words == '0) ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            rden = credit_ok;
            if (credit_ok && issue_left == NW'(1))
               state_nx = (C_RD_LATENCY > 1) ? FLUSH : DRAIN;
         end
         FLUSH: begin
            busy = 1'b1;
            rden = credit_ok;
            if (credit_ok && flush_left == LW'(1)) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if ((fifo_empty && out_left == '0) || last_accept) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= '0;
         issue_left <= '0;
         out_left   <= '0;
         flush_left <= '0;
         tag        <= '0;
      end else begin
         tag <= tag_nx;
         if (state == IDLE && start) begin
            addr_q     <= base_addr;
            issue_left <= num_words;
            out_left   <= num_words;
            flush_left <= LW'(C_RD_LATENCY - 1);
         end else begin
            // rdAddr stays on the last real address through the dummy pulses.
            if (rden && issue_real) begin
               issue_left <= issue_left - NW'(1);
               if (issue_left != NW'(1)) addr_q <= addr_q + AW'(1);
            end
            if (rden && !issue_real) flush_left <= flush_left - LW'(1);
            if (pop) out_left <= out_left - NW'(1);
         end
      end
   end

   rd_stream_skid_fifo #(
      .DEPTH (C_SKID_DEPTH),
      .WIDTH (C_RAM_RD_WIDTH)
   ) u_skid_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_pending),
      .push_data (ram_dout),
      .pop       (pop),
      .pop_data  (fifo_data),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_ram_rd_stream_ctrl.sv
// tb/tb_ram_rd_stream_ctrl.sv - directed vector bench for ram_rd_stream_ctrl
module tb_ram_rd_stream_ctrl;

   localparam int W     = 32;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int L     = 3;
   localparam int SKID  = 4;
   localparam int LIMIT = 3000;

   typedef struct {
      int base;
      int len;
      int hold;
      int restart;
      int exp_rden;
      int exp_hold_rden;
      int exp_first;
      int exp_last;
      int exp_lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          m_ready = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   num_words = '0;
   logic          busy, done, rden, m_valid, m_last;
   logic [AW-1:0] rdAddr;
   logic [W-1:0]  ram_dout, m_data;
   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  pipe [L] = '{default: 32'hDEAD_BEEF};

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int start_cyc = 0;
   int rden_addr[$];
   int words[$];
   bit lasts[$];
   int done_cnt, done_cyc, last_acc_cyc, first_valid_cyc, cur_len, overflow;

   always #5 clk = ~clk;

   ram_rd_stream_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .rdAddr    (rdAddr),
      .rden      (rden),
      .ram_dout  (ram_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rden) begin
         pipe[0] <= mem[rdAddr];
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign ram_dout = pipe[L-1];

   always @(negedge clk) begin
      if (!rst) begin
         if (rden) rden_addr.push_back(int'(rdAddr));
         if (((rden_addr.size() < cur_len) ? rden_addr.size() : cur_len) - words.size() > SKID) overflow++;
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid && m_ready) begin
            words.push_back(int'(m_data));
            lasts.push_back(m_last);
            last_acc_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      rden_addr.delete();
      words.delete();
      lasts.delete();
      done_cnt = 0;
      done_cyc = 0;
      last_acc_cyc = 0;
      first_valid_cyc = -1;
      overflow = 0;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int hold_rden;
      int bad;
      int c;
      int ea;
      clear_mon();
      cur_len   = v.len;
      hold_rden = -1;
      base_addr = AW'(v.base);
      num_words = (AW+1)'(v.len);
      m_ready   = (v.hold == 0);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      start_cyc = cyc;
      c = 0;
      while (done_cnt == 0 && c < LIMIT) begin
         if (v.hold > 0 && c == v.hold) begin
            hold_rden = rden_addr.size();
            m_ready   = 1'b1;
         end
         if (v.restart > 0 && c == v.restart) begin
            start     = 1'b1;
            base_addr = AW'(777);
            num_words = (AW+1)'(3);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({nm, ".done_seen"}, longint'(done_cnt > 0), 1);
      check({nm, ".done_once"}, done_cnt, 1);
      check({nm, ".rden_count"}, rden_addr.size(), v.exp_rden);
      check({nm, ".word_count"}, words.size(), v.len);
      if (v.hold > 0) check({nm, ".hold_rden"}, hold_rden, v.exp_hold_rden);
      if (v.len > 0) begin
         if (words.size() > 0) begin
            check({nm, ".first_word"}, words[0], v.exp_first);
            check({nm, ".last_word"}, words[words.size()-1], v.exp_last);
         end
         check({nm, ".first_latency"}, first_valid_cyc - start_cyc, v.exp_lat);
         check({nm, ".done_after_last"}, done_cyc - last_acc_cyc, 1);
         bad = -1;
         for (int k = 0; k < words.size(); k++) begin
            if (bad < 0 && (words[k] != (v.base + k) % DEPTH || lasts[k] != (k == v.len - 1))) bad = k;
         end
         check({nm, ".stream_first_bad_idx"}, bad, -1);
         bad = -1;
         for (int k = 0; k < rden_addr.size(); k++) begin
            ea = (k < v.len) ? (v.base + k) % DEPTH : (v.base + v.len - 1) % DEPTH;
            if (bad < 0 && rden_addr[k] != ea) bad = k;
         end
         check({nm, ".rdaddr_first_bad_idx"}, bad, -1);
      end else begin
         check({nm, ".len0_done_within_2"}, longint'(done_cyc - start_cyc <= 2), 1);
      end
      check({nm, ".credit_overflow"}, overflow, 0);
      check({nm, ".idle_after"}, {busy, m_valid}, 0);
   endtask

   vec_t vecs [7];
   vec_t post;

   initial begin
      int c;
      //          base  len  hold rst  rden hrden first last lat
      vecs[0] = '{0,    4,   0,   0,   6,   -1,   0,    3,   4};
      vecs[1] = '{200,  16,  20,  0,   18,  4,    200,  215, 4};
      vecs[2] = '{1022, 4,   0,   0,   6,   -1,   1022, 1,   4};
      vecs[3] = '{5,    0,   0,   0,   0,   -1,   -1,   -1,  -1};
      vecs[4] = '{7,    1,   3,   0,   3,   3,    7,    7,   4};
      vecs[5] = '{40,   8,   0,   3,   10,  -1,   40,   47,  4};
      vecs[6] = '{512,  1024, 0,  0,   1026, -1,  512,  511, 4};
      post    = '{100,  2,   0,   0,   4,   -1,   100,  101, 4};

      clear_mon();
      cur_len = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {busy, done, rden, m_valid, m_last, rdAddr, m_data}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      clear_mon();
      cur_len   = 10;
      base_addr = AW'(300);
      num_words = (AW+1)'(10);
      m_ready   = 1'b1;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (words.size() < 3 && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("rst_mid.three_words", longint'(words.size() >= 3), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid.outputs", {busy, done, rden, m_valid, m_last, rdAddr, m_data}, 0);
      check("rst_mid.no_done", done_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_vec(post, "rst_mid.next_burst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
